// File: rtl/vbs_raster_generator_pkg.sv
// ============================================================================
// vbs_raster_generator_pkg : PAL default raster constants and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package vbs_raster_generator_pkg;

  localparam int unsigned PAL_H_TOTAL       = 512;
  localparam int unsigned PAL_V_TOTAL       = 313;
  localparam int unsigned PAL_HSYNC_START   = 2;
  localparam int unsigned PAL_HSYNC_WIDTH   = 29;
  localparam int unsigned PAL_VSYNC_LINES   = 4;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vbs_sync_timing.sv
// ============================================================================
// vbs_sync_timing : h/v raster counters, composite sync and frame-start strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module vbs_sync_timing
  import vbs_raster_generator_pkg::*;
#(
  parameter int unsigned H_TOTAL     = PAL_H_TOTAL,
  parameter int unsigned V_TOTAL     = PAL_V_TOTAL,
  parameter int unsigned HSYNC_START = PAL_HSYNC_START,
  parameter int unsigned HSYNC_WIDTH = PAL_HSYNC_WIDTH,
  parameter int unsigned VSYNC_LINES = PAL_VSYNC_LINES,
  parameter int unsigned HW          = cnt_width(H_TOTAL),
  parameter int unsigned VW          = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          resetN,
  output logic          sync,
  output logic          frameStart,
  output logic [HW-1:0] hCount,
  output logic [VW-1:0] vCount
);

  localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] c_HS_FIRST = HW'(HSYNC_START);
  localparam logic [HW-1:0] c_HS_LAST  = HW'(HSYNC_START + HSYNC_WIDTH - 1);
  localparam logic [VW-1:0] c_VS_LINES = VW'(VSYNC_LINES);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          sync_q, sync_d;
  logic          fs_q, fs_d;
  logic          w_pulse;

  // Counters lead the registered outputs by one clock: sync/frameStart
  // visible in a cycle describe the position counted in the previous one.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == c_H_LAST) begin
      h_d = '0;
      v_d = (v_q == c_V_LAST) ? '0 : v_q + 1'b1;
    end
    w_pulse = (h_q >= c_HS_FIRST) && (h_q <= c_HS_LAST);
    sync_d  = (v_q < c_VS_LINES) ? w_pulse : ~w_pulse;
    fs_d    = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_q    <= '0;
      v_q    <= '0;
      sync_q <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      sync_q <= sync_d;
      fs_q   <= fs_d;
    end
  end

  assign sync       = sync_q;
  assign frameStart = fs_q;
  assign hCount     = h_q;
  assign vCount     = v_q;

endmodule

`default_nettype wire

// File: rtl/vbs_raster_generator.sv
// ============================================================================
// vbs_raster_generator : composite sync plus 1-bit bitmap window from video RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module vbs_raster_generator
  import vbs_raster_generator_pkg::*;
#(
  parameter int unsigned H_TOTAL       = PAL_H_TOTAL,
  parameter int unsigned V_TOTAL       = PAL_V_TOTAL,
  parameter int unsigned HSYNC_START   = PAL_HSYNC_START,
  parameter int unsigned HSYNC_WIDTH   = PAL_HSYNC_WIDTH,
  parameter int unsigned VSYNC_LINES   = PAL_VSYNC_LINES,
  parameter int unsigned X_START       = 96,
  parameter int unsigned Y_START       = 35,
  parameter int unsigned BYTES_PER_ROW = 16,
  parameter int unsigned ROWS          = 128,
  parameter int unsigned LINE_REPEAT   = 2,
  parameter int unsigned ADDR_WIDTH    = 11
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  invert,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  output logic                  memRead,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [7:0]            memData,
  output logic                  sync,
  output logic                  pixel,
  output logic                  active,
  output logic                  frameStart
);

  localparam int unsigned HW = cnt_width(H_TOTAL);
  localparam int unsigned VW = cnt_width(V_TOTAL);
  localparam int unsigned RW = cnt_width(LINE_REPEAT);
  localparam int unsigned BW = cnt_width(BYTES_PER_ROW);

  localparam logic [HW-1:0]         c_X_FETCH   = HW'(X_START - 2);
  localparam logic [HW-1:0]         c_X_FIRST   = HW'(X_START);
  localparam logic [HW-1:0]         c_X_LAST    = HW'(X_START + 8 * BYTES_PER_ROW - 1);
  localparam logic [HW-1:0]         c_H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]         c_Y_FIRST   = VW'(Y_START);
  localparam logic [VW-1:0]         c_Y_LAST    = VW'(Y_START + ROWS * LINE_REPEAT - 1);
  localparam logic [RW-1:0]         c_REP_LAST  = RW'(LINE_REPEAT - 1);
  localparam logic [BW-1:0]         c_LEFT_INIT = BW'(BYTES_PER_ROW - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ROW_STEP  = ADDR_WIDTH'(BYTES_PER_ROW);

  if ((X_START < 2) || (LINE_REPEAT < 1) ||
      (X_START + 8 * BYTES_PER_ROW > H_TOTAL) ||
      (Y_START + ROWS * LINE_REPEAT > V_TOTAL)) begin : g_bad_geometry
    $error("vbs_raster_generator: bitmap window does not fit the raster");
  end

  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;

  vbs_sync_timing #(
    .H_TOTAL     (H_TOTAL),
    .V_TOTAL     (V_TOTAL),
    .HSYNC_START (HSYNC_START),
    .HSYNC_WIDTH (HSYNC_WIDTH),
    .VSYNC_LINES (VSYNC_LINES),
    .HW          (HW),
    .VW          (VW)
  ) u_sync (
    .clk        (clk),
    .resetN     (resetN),
    .sync       (sync),
    .frameStart (frameStart),
    .hCount     (hCount),
    .vCount     (vCount)
  );

  logic                  armed_q;
  logic                  en_q, en_d, inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, addr_q, addr_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [BW-1:0]         left_q, left_d;
  logic [2:0]            ph_q, ph_d;
  logic                  fetch_q, fetch_d, rd_q, rd_d, load_q;
  logic [7:0]            shift_q, shift_d;
  logic                  act_q, act_d, pix_q, pix_d;
  logic                  w_fs, w_win, w_start, w_next;
  logic [ADDR_WIDTH-1:0] w_row;

  always_comb begin
    w_fs  = (hCount == '0) && (vCount == '0);
    // The first frame start after reset only arms the latch, so frame 0 is dark.
    en_d  = w_fs ? (enable & armed_q) : en_q;
    inv_d = w_fs ? invert : inv_q;
    w_row = w_fs ? baseAddr : row_q;
    w_win = en_d && (vCount >= c_Y_FIRST) && (vCount <= c_Y_LAST);

    row_d = w_row;
    rep_d = w_fs ? '0 : rep_q;
    if (w_win && (hCount == c_H_LAST)) begin
      if (rep_q == c_REP_LAST) begin
        rep_d = '0;
        row_d = row_q + c_ROW_STEP;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end

    // One read every 8 clocks: the phase counter returns to 0 eight clocks after each read.
    w_start = w_win && (hCount == c_X_FETCH);
    w_next  = fetch_q && (ph_q == 3'd0);
    rd_d    = w_start | w_next;
    addr_d  = addr_q;
    left_d  = left_q;
    fetch_d = fetch_q;
    ph_d    = ph_q + 3'd1;
    if (w_start) begin
      addr_d  = w_row;
      left_d  = c_LEFT_INIT;
      fetch_d = (c_LEFT_INIT != '0);
      ph_d    = 3'd1;
    end else if (w_next) begin
      addr_d  = addr_q + 1'b1;
      left_d  = left_q - 1'b1;
      fetch_d = (left_q != BW'(1));
      ph_d    = 3'd1;
    end

    shift_d = load_q ? memData : {shift_q[6:0], 1'b0};
    act_d   = w_win && (hCount >= c_X_FIRST) && (hCount <= c_X_LAST);
    pix_d   = act_d & (shift_d[7] ^ inv_q);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed_q <= 1'b0;
      en_q    <= 1'b0;
      inv_q   <= 1'b0;
      row_q   <= '0;
      addr_q  <= '0;
      rep_q   <= '0;
      left_q  <= '0;
      ph_q    <= '0;
      fetch_q <= 1'b0;
      rd_q    <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= '0;
      act_q   <= 1'b0;
      pix_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      en_q    <= en_d;
      inv_q   <= inv_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      rep_q   <= rep_d;
      left_q  <= left_d;
      ph_q    <= ph_d;
      fetch_q <= fetch_d;
      rd_q    <= rd_d;
      load_q  <= rd_q;
      shift_q <= shift_d;
      act_q   <= act_d;
      pix_q   <= pix_d;
    end
  end

  assign memRead = rd_q;
  assign memAddr = addr_q;
  assign active  = act_q;
  assign pixel   = pix_q;

endmodule

`default_nettype wire

// File: tb/tb_vbs_raster_generator.sv
// ============================================================================
// tb_vbs_raster_generator : randomized frames against a position-based raster model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vbs_raster_generator;

  localparam int H     = 64;
  localparam int V     = 24;
  localparam int HS    = 2;
  localparam int HSW   = 5;
  localparam int VS    = 2;
  localparam int X0    = 10;
  localparam int Y0    = 4;
  localparam int B     = 4;
  localparam int ROWS  = 4;
  localparam int LR    = 2;
  localparam int AW    = 6;
  localparam int FRAME = H * V;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          enable = 1'b1;
  logic          invert = 1'b1;
  logic [AW-1:0] baseAddr = 5;
  logic          memRead;
  logic [AW-1:0] memAddr;
  logic [7:0]    memData = 8'h00;
  logic          sync, pixel, active, frameStart;

  vbs_raster_generator #(
    .H_TOTAL(H), .V_TOTAL(V), .HSYNC_START(HS), .HSYNC_WIDTH(HSW),
    .VSYNC_LINES(VS), .X_START(X0), .Y_START(Y0), .BYTES_PER_ROW(B),
    .ROWS(ROWS), .LINE_REPEAT(LR), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .invert(invert),
    .baseAddr(baseAddr), .memRead(memRead), .memAddr(memAddr),
    .memData(memData), .sync(sync), .pixel(pixel), .active(active),
    .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:DEPTH-1];

  // Synchronous video RAM: data valid in the cycle after the strobe.
  always @(posedge clk) begin
    if (memRead) memData <= ram[memAddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int   p = 0;
  int   fen, finv, fbase;
  int   rd_cnt = 0;
  int   exp_rd_cnt = 0;

  task automatic tick();
    int h, v, f, row, rel, k, b;
    logic pulse, e_sync, e_fs, win, e_rd, e_act, e_pix;
    logic [7:0] bytev;
    @(negedge clk);
    h = p % H;
    v = (p / H) % V;
    f = p / FRAME;
    if (h == 0 && v == 0) begin
      if (p > 0) chk("reads_per_frame", rd_cnt, exp_rd_cnt);
      rd_cnt     = 0;
      fen        = (p == 0) ? 0 : int'(enable);
      finv       = int'(invert);
      fbase      = int'(baseAddr);
      exp_rd_cnt = fen ? ROWS * LR * B : 0;
      for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
      if (f == 1) begin
        ram[0] = 8'h81;
        ram[1] = 8'hFF;
      end
    end
    pulse  = (h >= HS) && (h <= HS + HSW - 1);
    e_sync = (v < VS) ? pulse : !pulse;
    e_fs   = (h == 0) && (v == 0);
    win    = (fen != 0) && (v >= Y0) && (v < Y0 + ROWS * LR);
    row    = (v - Y0) / LR;
    rel    = h - (X0 - 2);
    e_rd   = win && (rel >= 0) && (rel % 8 == 0) && (rel / 8 < B);
    e_act  = win && (h >= X0) && (h < X0 + 8 * B);
    e_pix  = 1'b0;
    if (e_act) begin
      k     = (h - X0) / 8;
      b     = (h - X0) % 8;
      bytev = ram[(fbase + row * B + k) % DEPTH];
      e_pix = bytev[7 - b] ^ (finv != 0);
    end
    chk("sync", sync, e_sync);
    chk("frameStart", frameStart, e_fs);
    chk("memRead", memRead, e_rd);
    chk("active", active, e_act);
    chk("pixel", pixel, e_pix);
    if (e_rd) chk("memAddr", memAddr, (fbase + row * B + rel / 8) % DEPTH);
    if (memRead) rd_cnt++;
    // Inputs change mid-window; they must only take effect at the next frame start.
    if (v == 6 && h == 20) begin
      case (f + 1)
        1:  begin enable = 1'b1; invert = 1'b0; baseAddr = '0; end
        2:  begin enable = 1'b1; invert = 1'b1; baseAddr = AW'(DEPTH - 2); end
        3:  begin enable = 1'b0; invert = 1'b1; baseAddr = 3; end
        10: begin enable = 1'b1; invert = 1'b0; baseAddr = AW'($urandom); end
        default: begin
          enable   = ($urandom_range(0, 3) != 0);
          invert   = 1'($urandom);
          baseAddr = AW'($urandom);
        end
      endcase
    end
    p++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sync"}, sync, 1'b1);
    chk({tag, "_pixel"}, pixel, 1'b0);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_memRead"}, memRead, 1'b0);
    chk({tag, "_memAddr"}, memAddr, 0);
    chk({tag, "_frameStart"}, frameStart, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    resetN = 1'b1;
    p = 0;
    repeat (10 * FRAME + 8 * H + 20) tick();

    // Frame 10 is enabled; assert reset inside the window.
    @(negedge clk);
    chk("pre_reset_active", active, 1'b1);
    resetN = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    chk_reset_outputs("held");
    resetN = 1'b1;
    p = 0;
    repeat (2 * FRAME + 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
